uart_receiver_controller: RTL

UART_RECEIVER_CONTROLLER -- requirements
Module: UART_receiver_controller

---
 rtl/uart_receiver_controller.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver_controller.sv
// uart_receiver_controller
// Decodes command frames arriving from a UART receiver into register-file
// writes/reads and ALU start requests. Every output is registered.
//   0xAA addr data      -> register write
//   0xBB addr           -> register read
//   0xCC opA opB func   -> writes opA@0, opB@1, then starts the ALU
//   0xDD func           -> starts the ALU
// Optional feature macro: FRAME_TIMEOUT_EN (abort a partial frame after
// TIMEOUT_CYCLES clock cycles with no valid byte).
module uart_receiver_controller #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDRESS_WIDTH      = 4,
  parameter int ALU_FUNCTION_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 16384
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         receiver_parallel_data,
  input  logic                          receiver_parallel_data_valid,
  input  logic                          UART_receiver_controller_enable,
  output logic [ADDRESS_WIDTH-1:0]      address,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          read_enable,
  output logic [ALU_FUNCTION_WIDTH-1:0] ALU_function,
  output logic                          ALU_enable,
  output logic                          clock_gate_enable
);

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OPERANDS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_ONLY = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_ADDR   = 3'd1,
    WR_DATA   = 3'd2,
    RD_ADDR   = 3'd3,
    OPERAND_A = 3'd4,
    OPERAND_B = 3'd5,
    ALU_FUNC  = 3'd6
  } state_t;

  state_t                          state_r;
  state_t                          next_state_s;
  logic [ADDRESS_WIDTH-1:0]        next_address_s;
  logic [DATA_WIDTH-1:0]           next_write_data_s;
  logic [ALU_FUNCTION_WIDTH-1:0]   next_alu_function_s;
  logic                            next_write_enable_s;
  logic                            next_read_enable_s;
  logic                            next_alu_enable_s;
  logic                            next_clock_gate_enable_s;

`ifdef FRAME_TIMEOUT_EN
  localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMEOUT_WIDTH-1:0] idle_count_r;
  logic [TIMEOUT_WIDTH-1:0] next_idle_count_s;
  logic                     timeout_hit_s;

  // Count idle cycles inside a frame and flag the cycle that reaches the limit.
  always_comb begin
    next_idle_count_s = {TIMEOUT_WIDTH{1'b0}};
    timeout_hit_s     = 1'b0;
    if ((state_r != IDLE) && !receiver_parallel_data_valid) begin
      if (idle_count_r == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit_s = 1'b1;
      end else begin
        next_idle_count_s = idle_count_r + TIMEOUT_WIDTH'(1'b1);
      end
    end else begin
      next_idle_count_s = {TIMEOUT_WIDTH{1'b0}};
    end
  end

  // Idle-cycle counter register; cleared by reset, valid bytes and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_count_r <= {TIMEOUT_WIDTH{1'b0}};
    end else begin
      idle_count_r <= next_idle_count_s;
    end
  end
`else
  // Partial frames wait indefinitely; TIMEOUT_CYCLES has no effect here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Next-state decode and next values of the registered outputs.
  always_comb begin
    next_state_s        = state_r;
    next_address_s      = address;
    next_write_data_s   = write_data;
    next_alu_function_s = ALU_function;
    next_write_enable_s = 1'b0;
    next_read_enable_s  = 1'b0;
    next_alu_enable_s   = 1'b0;
    if (receiver_parallel_data_valid) begin
      case (state_r)
        IDLE: begin
          // Only command bytes are gated by the enable; continuation bytes are not.
          if (UART_receiver_controller_enable) begin
            case (receiver_parallel_data)
              CMD_WRITE:        next_state_s = WR_ADDR;
              CMD_READ:         next_state_s = RD_ADDR;
              CMD_ALU_OPERANDS: next_state_s = OPERAND_A;
              CMD_ALU_ONLY:     next_state_s = ALU_FUNC;
              default:          next_state_s = IDLE;
            endcase
          end else begin
            next_state_s = IDLE;
          end
        end
        WR_ADDR: begin
          next_address_s = receiver_parallel_data[ADDRESS_WIDTH-1:0];
          next_state_s   = WR_DATA;
        end
        WR_DATA: begin
          next_write_data_s   = receiver_parallel_data;
          next_write_enable_s = 1'b1;
          next_state_s        = IDLE;
        end
        RD_ADDR: begin
          next_address_s     = receiver_parallel_data[ADDRESS_WIDTH-1:0];
          next_read_enable_s = 1'b1;
          next_state_s       = IDLE;
        end
        OPERAND_A: begin
          next_address_s      = {ADDRESS_WIDTH{1'b0}};
          next_write_data_s   = receiver_parallel_data;
          next_write_enable_s = 1'b1;
          next_state_s        = OPERAND_B;
        end
        OPERAND_B: begin
          next_address_s      = ADDRESS_WIDTH'(1'b1);
          next_write_data_s   = receiver_parallel_data;
          next_write_enable_s = 1'b1;
          next_state_s        = ALU_FUNC;
        end
        ALU_FUNC: begin
          next_alu_function_s = receiver_parallel_data[ALU_FUNCTION_WIDTH-1:0];
          next_alu_enable_s   = 1'b1;
          next_state_s        = IDLE;
        end
        default: next_state_s = IDLE;
      endcase
    end else begin
`ifdef FRAME_TIMEOUT_EN
      if (timeout_hit_s) begin
        next_state_s = IDLE;
      end else begin
        next_state_s = state_r;
      end
`else
      next_state_s = state_r;
`endif
    end
    // The ALU clock runs for the whole operand/function phase and the start cycle.
    next_clock_gate_enable_s = (next_state_s == OPERAND_A) || (next_state_s == OPERAND_B) ||
                               (next_state_s == ALU_FUNC) || next_alu_enable_s;
  end

  // State and output registers; strobes fall back to 0 unless re-fired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= IDLE;
      address           <= {ADDRESS_WIDTH{1'b0}};
      write_data        <= {DATA_WIDTH{1'b0}};
      ALU_function      <= {ALU_FUNCTION_WIDTH{1'b0}};
      write_enable      <= 1'b0;
      read_enable       <= 1'b0;
      ALU_enable        <= 1'b0;
      clock_gate_enable <= 1'b0;
    end else begin
      state_r           <= next_state_s;
      address           <= next_address_s;
      write_data        <= next_write_data_s;
      ALU_function      <= next_alu_function_s;
      write_enable      <= next_write_enable_s;
      read_enable       <= next_read_enable_s;
      ALU_enable        <= next_alu_enable_s;
      clock_gate_enable <= next_clock_gate_enable_s;
    end
  end

endmodule
